// File: rtl/pilot_interp_3.sv
// pilot_interp_3: sequential linear interpolator for channel estimation.
// Takes one complex pilot per three subcarriers and emits one estimate per
// subcarrier. The two intermediate points use d*21>>>6 (about d/3) and twice
// that value. The last segment is extrapolated with the final pilot slope.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no symbol in flight, waiting for pilot 0
// WAIT  | base pilot held in a, waiting for the next pilot
// EMIT  | streaming a, a+t1, a+t2 for the current segment
// TAIL  | streaming b, b+t1, b+t2 past the last pilot, reusing the last d
module pilot_interp_3 #(
    parameter int IN_WIDTH   = 16,
    parameter int NUM_PILOTS = 4,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [IN_WIDTH-1:0]  pilot_re,
    input  logic signed [IN_WIDTH-1:0]  pilot_im,
    input  logic                        pilot_valid,
    output logic                        pilot_ready,
    output logic signed [IN_WIDTH-1:0]  out_re,
    output logic signed [IN_WIDTH-1:0]  out_im,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_WIDTH-1:0]        out_idx,
    output logic                        out_last
);

    localparam int PCW = $clog2(NUM_PILOTS + 1);
    localparam logic signed [IN_WIDTH+5:0] K21 = (IN_WIDTH + 6)'(21);
    localparam logic signed [IN_WIDTH+1:0] SAT_HI = (IN_WIDTH + 2)'(2 ** (IN_WIDTH - 1) - 1);
    localparam logic signed [IN_WIDTH+1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EMIT = 2'd2,
        S_TAIL = 2'd3
    } state_t;

    state_t                       state;
    logic signed [IN_WIDTH-1:0]   a_re, a_im, b_re, b_im;
    logic signed [IN_WIDTH:0]     d_re, d_im;
    logic [PCW-1:0]               pcnt;
    logic [1:0]                   phase;

    logic signed [IN_WIDTH:0]     t1_re, t1_im;
    logic signed [IN_WIDTH:0]     dn_re, dn_im;
    logic signed [IN_WIDTH-1:0]   base_re, base_im;
    logic signed [IN_WIDTH-1:0]   nxt_re, nxt_im;

    // floor(d*21/64): the 1/3 step, kept at IN_WIDTH+1 bits
    function automatic logic signed [IN_WIDTH:0] step_third(input logic signed [IN_WIDTH:0] d);
        logic signed [IN_WIDTH+5:0] prod;
        prod = $signed({{5{d[IN_WIDTH]}}, d}) * K21;
        prod = prod >>> 6;
        return prod[IN_WIDTH:0];
    endfunction

    function automatic logic signed [IN_WIDTH-1:0] sat(input logic signed [IN_WIDTH+1:0] x);
        if (x > SAT_HI) begin
            return SAT_HI[IN_WIDTH-1:0];
        end else if (x < SAT_LO) begin
            return SAT_LO[IN_WIDTH-1:0];
        end
        return x[IN_WIDTH-1:0];
    endfunction

    // base + t1 (sel2=0) or base + 2*t1 (sel2=1), saturated
    function automatic logic signed [IN_WIDTH-1:0] interp(
        input logic signed [IN_WIDTH-1:0] base,
        input logic signed [IN_WIDTH:0]   t1,
        input logic                       sel2
    );
        logic signed [IN_WIDTH+1:0] off;
        logic signed [IN_WIDTH+1:0] sum;
        off = sel2 ? {t1, 1'b0} : {t1[IN_WIDTH], t1};
        sum = {{2{base[IN_WIDTH-1]}}, base} + off;
        return sat(sum);
    endfunction

    // next output candidates for the current phase; TAIL extrapolates from b
    always_comb begin
        t1_re   = step_third(d_re);
        t1_im   = step_third(d_im);
        base_re = (state == S_TAIL) ? b_re : a_re;
        base_im = (state == S_TAIL) ? b_im : a_im;
        nxt_re  = interp(base_re, t1_re, phase[0]);
        nxt_im  = interp(base_im, t1_im, phase[0]);
        dn_re   = {pilot_re[IN_WIDTH-1], pilot_re} - {a_re[IN_WIDTH-1], a_re};
        dn_im   = {pilot_im[IN_WIDTH-1], pilot_im} - {a_im[IN_WIDTH-1], a_im};
    end

    assign pilot_ready = (state == S_IDLE) || (state == S_WAIT);
    assign out_last    = out_valid && (state == S_TAIL) && (phase == 2'd2);

    // sequencing FSM with registered datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_re      <= '0;
            a_im      <= '0;
            b_re      <= '0;
            b_im      <= '0;
            d_re      <= '0;
            d_im      <= '0;
            pcnt      <= '0;
            phase     <= '0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    out_idx <= '0;
                    phase   <= '0;
                    if (pilot_valid) begin
                        a_re  <= pilot_re;
                        a_im  <= pilot_im;
                        pcnt  <= PCW'(1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pilot_valid) begin
                        b_re      <= pilot_re;
                        b_im      <= pilot_im;
                        d_re      <= dn_re;
                        d_im      <= dn_im;
                        pcnt      <= pcnt + 1'b1;
                        out_re    <= a_re;
                        out_im    <= a_im;
                        phase     <= '0;
                        out_valid <= 1'b1;
                        state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_idx <= out_idx + 1'b1;
                        if (phase != 2'd2) begin
                            out_re <= nxt_re;
                            out_im <= nxt_im;
                            phase  <= phase + 2'd1;
                        end else begin
                            a_re <= b_re;
                            a_im <= b_im;
                            if (pcnt < PCW'(NUM_PILOTS)) begin
                                out_valid <= 1'b0;
                                state     <= S_WAIT;
                            end else begin
                                out_re <= b_re;
                                out_im <= b_im;
                                phase  <= '0;
                                state  <= S_TAIL;
                            end
                        end
                    end
                end
                S_TAIL: begin
                    if (out_ready) begin
                        if (phase != 2'd2) begin
                            out_re  <= nxt_re;
                            out_im  <= nxt_im;
                            phase   <= phase + 2'd1;
                            out_idx <= out_idx + 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                            phase     <= '0;
                            out_idx   <= '0;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
